// File: rtl/multalu_arbiter.sv
// multalu_arbiter: round-robin sharing of one MULTALU36X18 (DOUT = A*B + C)
// between two requesters, with a tag pipeline that routes each result back
// to the requester that issued it.
module multalu_arbiter #(
  parameter  int unsigned DSP_LATENCY = 1,
  localparam int unsigned AW = 18,
  localparam int unsigned BW = 36,
  localparam int unsigned CW = 54,
  localparam int unsigned DW = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_a,
  input  logic [BW-1:0] req0_b,
  input  logic [CW-1:0] req0_c,
  input  logic          req0_asign,
  input  logic          req0_bsign,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_a,
  input  logic [BW-1:0] req1_b,
  input  logic [CW-1:0] req1_c,
  input  logic          req1_asign,
  input  logic          req1_bsign,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_data,
  output logic [AW-1:0] dsp_a,
  output logic [BW-1:0] dsp_b,
  output logic [CW-1:0] dsp_c,
  output logic          dsp_asign,
  output logic          dsp_bsign,
  output logic          dsp_accload,
  output logic          dsp_ce,
  input  logic [DW-1:0] dsp_dout,
  output logic          busy
);

  localparam int unsigned LAST = DSP_LATENCY - 1;

  logic          last_grant;
  logic          xfer_c;
  logic          grant_c;
  logic          issue_valid;
  logic          issue_tag;
  logic          inflight_c;
  logic [AW-1:0] sel_a_c;
  logic [BW-1:0] sel_b_c;
  logic [CW-1:0] sel_c_c;
  logic          sel_asign_c;
  logic          sel_bsign_c;
  // one-hot owner per stage: bit0 = requester 0, bit1 = requester 1
  logic [1:0]    tag_pipe [DSP_LATENCY];

  // Round-robin grant: contention goes to the requester that did not win last
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset) begin
      if (req0_valid && req1_valid) begin
        req0_ready = last_grant;
        req1_ready = !last_grant;
      end else begin
        req0_ready = req0_valid;
        req1_ready = req1_valid;
      end
    end
  end

  assign xfer_c  = req0_ready | req1_ready;
  assign grant_c = req1_ready;

  // Operand mux of the granted requester; zeros when nothing transfers
  always_comb begin
    sel_a_c     = '0;
    sel_b_c     = '0;
    sel_c_c     = '0;
    sel_asign_c = 1'b0;
    sel_bsign_c = 1'b0;
    if (req1_ready) begin
      sel_a_c     = req1_a;
      sel_b_c     = req1_b;
      sel_c_c     = req1_c;
      sel_asign_c = req1_asign;
      sel_bsign_c = req1_bsign;
    end else if (req0_ready) begin
      sel_a_c     = req0_a;
      sel_b_c     = req0_b;
      sel_c_c     = req0_c;
      sel_asign_c = req0_asign;
      sel_bsign_c = req0_bsign;
    end
  end

  // Remember the last winner; only a real transfer moves it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (xfer_c) begin
      last_grant <= grant_c;
    end
  end

  // Issue register driving the DSP input ports
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_valid <= 1'b0;
      issue_tag   <= 1'b0;
      dsp_a       <= '0;
      dsp_b       <= '0;
      dsp_c       <= '0;
      dsp_asign   <= 1'b0;
      dsp_bsign   <= 1'b0;
    end else begin
      issue_valid <= xfer_c;
      issue_tag   <= grant_c;
      dsp_a       <= sel_a_c;
      dsp_b       <= sel_b_c;
      dsp_c       <= sel_c_c;
      dsp_asign   <= sel_asign_c;
      dsp_bsign   <= sel_bsign_c;
    end
  end

  // Ownership shift register aligned with the DSP latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DSP_LATENCY; i++) begin
        tag_pipe[i] <= 2'b00;
      end
    end else begin
      tag_pipe[0] <= {issue_valid & issue_tag, issue_valid & ~issue_tag};
      for (int unsigned i = 1; i < DSP_LATENCY; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  // Stages that will still hold an operation after the next edge
  always_comb begin
    inflight_c = 1'b0;
    for (int unsigned i = 0; i + 1 < DSP_LATENCY; i++) begin
      inflight_c = inflight_c | (|tag_pipe[i]);
    end
  end

  // busy registered from the next-state of the issue stage and tag pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
    end else begin
      busy <= xfer_c | issue_valid | inflight_c;
    end
  end

  assign rsp0_valid  = tag_pipe[LAST][0];
  assign rsp1_valid  = tag_pipe[LAST][1];
  assign rsp0_data   = dsp_dout;
  assign rsp1_data   = dsp_dout;
  assign dsp_accload = 1'b0;
  assign dsp_ce      = 1'b1;

endmodule

// File: tb/tb_multalu_arbiter.sv
// Scoreboard bench for multalu_arbiter: one instance with DSP_LATENCY=1 and
// one with DSP_LATENCY=3 share the same requester stimulus, each feeding its
// own behavioural DSP model.
module tb_multalu_arbiter;

  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 3;

  typedef struct packed {
    logic [17:0] a;
    logic [35:0] b;
    logic [53:0] c;
    logic        asign;
    logic        bsign;
    logic [63:0] exp;
  } op_t;

  typedef struct {
    logic        tag;
    logic [63:0] data;
    int          due;
  } sb_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   nchk = 0;
  int   nfail = 0;

  logic        req0_valid, req0_asign, req0_bsign;
  logic [17:0] req0_a;
  logic [35:0] req0_b;
  logic [53:0] req0_c;
  logic        req1_valid, req1_asign, req1_bsign;
  logic [17:0] req1_a;
  logic [35:0] req1_b;
  logic [53:0] req1_c;

  logic        rdy0 [2];
  logic        rdy1 [2];
  logic        r0v  [2];
  logic        r1v  [2];
  logic [63:0] r0d  [2];
  logic [63:0] r1d  [2];
  logic [17:0] da   [2];
  logic [35:0] db   [2];
  logic [53:0] dc   [2];
  logic        das  [2];
  logic        dbs  [2];
  logic        dacc [2];
  logic        dce  [2];
  logic [63:0] dout [2];
  logic        bsy  [2];

  sb_t sbq0[$];
  sb_t sbq1[$];
  op_t tbl [12];
  op_t zop;
  op_t v_single;
  op_t v_signed;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multalu_arbiter #(.DSP_LATENCY(LAT_A)) u_l1 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(rdy0[0]), .req0_a(req0_a), .req0_b(req0_b),
    .req0_c(req0_c), .req0_asign(req0_asign), .req0_bsign(req0_bsign),
    .rsp0_valid(r0v[0]), .rsp0_data(r0d[0]),
    .req1_valid(req1_valid), .req1_ready(rdy1[0]), .req1_a(req1_a), .req1_b(req1_b),
    .req1_c(req1_c), .req1_asign(req1_asign), .req1_bsign(req1_bsign),
    .rsp1_valid(r1v[0]), .rsp1_data(r1d[0]),
    .dsp_a(da[0]), .dsp_b(db[0]), .dsp_c(dc[0]), .dsp_asign(das[0]), .dsp_bsign(dbs[0]),
    .dsp_accload(dacc[0]), .dsp_ce(dce[0]), .dsp_dout(dout[0]), .busy(bsy[0])
  );

  multalu_arbiter #(.DSP_LATENCY(LAT_B)) u_l3 (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(rdy0[1]), .req0_a(req0_a), .req0_b(req0_b),
    .req0_c(req0_c), .req0_asign(req0_asign), .req0_bsign(req0_bsign),
    .rsp0_valid(r0v[1]), .rsp0_data(r0d[1]),
    .req1_valid(req1_valid), .req1_ready(rdy1[1]), .req1_a(req1_a), .req1_b(req1_b),
    .req1_c(req1_c), .req1_asign(req1_asign), .req1_bsign(req1_bsign),
    .rsp1_valid(r1v[1]), .rsp1_data(r1d[1]),
    .dsp_a(da[1]), .dsp_b(db[1]), .dsp_c(dc[1]), .dsp_asign(das[1]), .dsp_bsign(dbs[1]),
    .dsp_accload(dacc[1]), .dsp_ce(dce[1]), .dsp_dout(dout[1]), .busy(bsy[1])
  );

  // Behavioural MULTALU36X18 MODE 0
  function automatic logic [63:0] dsp_calc(input logic [17:0] a, input logic [35:0] b,
                                           input logic [53:0] c, input logic as, input logic bs);
    logic [63:0] ae, be;
    ae = as ? {{46{a[17]}}, a} : {46'd0, a};
    be = bs ? {{28{b[35]}}, b} : {28'd0, b};
    return ae * be + {10'd0, c};
  endfunction

  logic [63:0] dp0 [LAT_A];
  logic [63:0] dp1 [LAT_B];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT_A; i++) dp0[i] <= '0;
    end else begin
      dp0[0] <= dsp_calc(da[0], db[0], dc[0], das[0], dbs[0]);
      for (int i = 1; i < LAT_A; i++) dp0[i] <= dp0[i-1];
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT_B; i++) dp1[i] <= '0;
    end else begin
      dp1[0] <= dsp_calc(da[1], db[1], dc[1], das[1], dbs[1]);
      for (int i = 1; i < LAT_B; i++) dp1[i] <= dp1[i-1];
    end
  end

  assign dout[0] = dp0[LAT_A-1];
  assign dout[1] = dp1[LAT_B-1];

  function automatic op_t mk(input logic [17:0] a, input logic [35:0] b, input logic [53:0] c,
                             input logic as, input logic bs, input logic [63:0] e);
    op_t o;
    o.a = a; o.b = b; o.c = c; o.asign = as; o.bsign = bs; o.exp = e;
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? sbq0.size() : sbq1.size();
  endfunction

  function automatic sb_t qhead(input int k);
    return (k == 0) ? sbq0[0] : sbq1[0];
  endfunction

  task automatic qpop(input int k);
    if (k == 0) void'(sbq0.pop_front());
    else        void'(sbq1.pop_front());
  endtask

  task automatic qpush(input int k, input logic tag, input logic [63:0] data, input int due);
    sb_t e;
    e.tag = tag; e.data = data; e.due = due;
    if (k == 0) sbq0.push_back(e);
    else        sbq1.push_back(e);
  endtask

  // Monitor: compare every presented response with the scoreboard head
  task automatic mon(input int k, input logic v0, input logic v1,
                     input logic [63:0] d0, input logic [63:0] d1);
    sb_t e;
    while (qsize(k) > 0 && qhead(k).due < cyc) begin
      e = qhead(k);
      qpop(k);
      nchk++; nfail++;
      $display("FAIL rsp_missing inst%0d: no response, required tag %0d at cycle %0d", k, e.tag, e.due);
    end
    if (v0 && v1) begin
      nchk++; nfail++;
      $display("FAIL rsp_both inst%0d: both rsp valids high at cycle %0d, required one", k, cyc);
    end
    if (v0 || v1) begin
      if (qsize(k) == 0) begin
        nchk++; nfail++;
        $display("FAIL rsp_unexpected inst%0d: rsp0=%0b rsp1=%0b at cycle %0d, required none", k, v0, v1, cyc);
      end else begin
        e = qhead(k);
        qpop(k);
        chk($sformatf("rsp_cycle_i%0d", k), 64'(cyc), 64'(e.due));
        chk($sformatf("rsp_tag_i%0d", k), 64'(v1), 64'(e.tag));
        chk($sformatf("rsp_data_i%0d", k), v1 ? d1 : d0, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, r0v[0], r1v[0], r0d[0], r1d[0]);
    mon(1, r0v[1], r1v[1], r0d[1], r1d[1]);
  end

  task automatic set_req(input logic v0, input op_t o0, input logic v1, input op_t o1);
    req0_valid = v0; req0_a = o0.a; req0_b = o0.b; req0_c = o0.c;
    req0_asign = o0.asign; req0_bsign = o0.bsign;
    req1_valid = v1; req1_a = o1.a; req1_b = o1.b; req1_c = o1.c;
    req1_asign = o1.asign; req1_bsign = o1.bsign;
  endtask

  // One request cycle: check the expected grant, then push expected responses
  task automatic cycle(input logic v0, input op_t o0, input logic v1, input op_t o1,
                       input logic g0, input logic g1);
    set_req(v0, o0, v1, o1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready0_i%0d", k), 64'(rdy0[k]), 64'(g0));
      chk($sformatf("ready1_i%0d", k), 64'(rdy1[k]), 64'(g1));
    end
    if (g0) begin
      qpush(0, 1'b0, o0.exp, cyc + 1 + LAT_A);
      qpush(1, 1'b0, o0.exp, cyc + 1 + LAT_B);
    end
    if (g1) begin
      qpush(0, 1'b1, o1.exp, cyc + 1 + LAT_A);
      qpush(1, 1'b1, o1.exp, cyc + 1 + LAT_B);
    end
    @(posedge clk); #1;
    set_req(1'b0, zop, 1'b0, zop);
  endtask

  task automatic idle(input int n);
    set_req(1'b0, zop, 1'b0, zop);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_ready0_i%0d", tag, k), 64'(rdy0[k]), 64'd0);
      chk($sformatf("%s_ready1_i%0d", tag, k), 64'(rdy1[k]), 64'd0);
      chk($sformatf("%s_busy_i%0d", tag, k), 64'(bsy[k]), 64'd0);
      chk($sformatf("%s_rsp0v_i%0d", tag, k), 64'(r0v[k]), 64'd0);
      chk($sformatf("%s_rsp1v_i%0d", tag, k), 64'(r1v[k]), 64'd0);
    end
  endtask

  // Reset pulse with both requesters asserting valid throughout
  task automatic do_reset();
    reset = 1'b1;
    sbq0.delete();
    sbq1.delete();
    set_req(1'b1, tbl[0], 1'b1, tbl[1]);
    @(negedge clk);
    chk_reset_outs("rst");
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outs("rst_hold");
    @(posedge clk); #1;
    reset = 1'b0;
    set_req(1'b0, zop, 1'b0, zop);
  endtask

  initial begin
    zop      = mk(18'd0, 36'd0, 54'd0, 1'b0, 1'b0, 64'd0);
    v_single = mk(18'h00002, 36'h5f76fe56f, 54'h10000, 1'b0, 1'b0, 64'h0000000BEEE0CADE);
    v_signed = mk(18'h3ffff, 36'hffffffffd, 54'd0, 1'b1, 1'b1, 64'h0000000000000003);
    tbl[0]  = mk(18'd3,      36'd5,           54'd1,   1'b0, 1'b0, 64'd16);
    tbl[1]  = mk(18'd7,      36'd6,           54'd0,   1'b0, 1'b0, 64'd42);
    tbl[2]  = mk(18'h10,     36'h100,         54'h5,   1'b0, 1'b0, 64'h1005);
    tbl[3]  = mk(18'd1,      36'd1,           54'd0,   1'b0, 1'b0, 64'd1);
    tbl[4]  = mk(18'h3fffe,  36'd7,           54'd0,   1'b1, 1'b0, 64'hFFFFFFFFFFFFFFF2);
    tbl[5]  = mk(18'd9,      36'd9,           54'd9,   1'b0, 1'b0, 64'h5A);
    tbl[6]  = mk(18'h20000,  36'd2,           54'd0,   1'b0, 1'b0, 64'h40000);
    tbl[7]  = mk(18'd5,      36'hfffffffff,   54'd0,   1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFB);
    tbl[8]  = mk(18'd100,    36'd100,         54'd0,   1'b0, 1'b0, 64'h2710);
    tbl[9]  = mk(18'h3ffff,  36'd1,           54'd1,   1'b0, 1'b0, 64'h40000);
    tbl[10] = mk(18'd12,     36'd12,          54'd0,   1'b0, 1'b0, 64'h90);
    tbl[11] = mk(18'd2,      36'h800000000,   54'd0,   1'b0, 1'b0, 64'h0000001000000000);

    set_req(1'b0, zop, 1'b0, zop);
    @(posedge clk); #1;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("accload_i%0d", k), 64'(dacc[k]), 64'd0);
      chk($sformatf("ce_i%0d", k), 64'(dce[k]), 64'd1);
    end

    // Single op on requester 0, with busy window per latency
    cycle(1'b1, v_single, 1'b0, zop, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("busy_single_l1_k%0d", k), 64'(bsy[0]), 64'(k <= 2));
      chk($sformatf("busy_single_l3_k%0d", k), 64'(bsy[1]), 64'(k <= 4));
      @(posedge clk); #1;
    end
    idle(2);

    // Signed op on requester 1
    cycle(1'b0, zop, 1'b1, v_signed, 1'b0, 1'b1);
    idle(6);

    // Contention from reset: strict alternation starting with requester 0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, tbl[2*i], 1'b1, tbl[2*i+1], (i % 2) == 0, (i % 2) == 1);
    end
    idle(6);

    // Back-to-back single requester
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, tbl[i], 1'b0, zop, 1'b1, 1'b0);
    end
    idle(6);

    // Reset one cycle after a handshake: that op must never return
    cycle(1'b1, tbl[8], 1'b0, zop, 1'b1, 1'b0);
    do_reset();
    cycle(1'b1, tbl[9], 1'b1, tbl[10], 1'b1, 1'b0);
    cycle(1'b1, tbl[11], 1'b1, tbl[0], 1'b0, 1'b1);
    idle(8);

    chk("sb_empty_l1", 64'(sbq0.size()), 64'd0);
    chk("sb_empty_l3", 64'(sbq1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
